// File: rtl/csr_trap_stack_pkg.sv
// csr_trap_stack_pkg: shared types, privilege encodings and helpers for the nested trap status stack.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: cvw_t core config, trapstk_entry_t save entry, MTRAPSTK field offsets,
//           count-width helper, MPP legalisation.
package csr_trap_stack_pkg;

   typedef struct packed {
      int   XLEN;
      logic S_SUPPORTED;
      logic U_SUPPORTED;
   } cvw_t;

   localparam cvw_t CVW_DEFAULT = '{XLEN: 64, S_SUPPORTED: 1'b1, U_SUPPORTED: 1'b1};

   localparam logic [1:0] M_MODE = 2'b11;
   localparam logic [1:0] S_MODE = 2'b01;
   localparam logic [1:0] U_MODE = 2'b00;

   // One saved level: previous interrupt enable and previous privilege.
   typedef struct packed {
      logic       pie;
      logic [1:0] pp;
   } trapstk_entry_t;

   // MTRAPSTK view layout: {0, S_ovf, M_ovf, S_count, M_count}.
   localparam int MTRAPSTK_CNT_W    = 4;
   localparam int MTRAPSTK_MCNT_LSB = 0;
   localparam int MTRAPSTK_SCNT_LSB = 4;
   localparam int MTRAPSTK_MOVF_BIT = 8;
   localparam int MTRAPSTK_SOVF_BIT = 9;

   // Width of the extra-level counter; never narrower than one bit.
   function automatic int trapstk_cnt_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Reserved or unsupported MPP encodings fall back to M.
   function automatic logic [1:0] legal_mpp(input logic [1:0] v, input logic s_sup, input logic u_sup);
      if (v == U_MODE && u_sup)      return U_MODE;
      else if (v == S_MODE && s_sup) return S_MODE;
      else                           return M_MODE;
   endfunction

endpackage

// File: rtl/csr_trap_stack_if.sv
// csr_trap_stack_if: groups the CSR-unit control inputs and status outputs of the trap stack.
// Latency: n/a (wiring only).
// Backpressure: StallW travels with the bundle and freezes the stack when high.
// Modports: master drives the events and write data, slave is the trap stack itself.
interface csr_trap_stack_if #(parameter int XLEN = 64);
   logic             StallW;
   logic             TrapM;
   logic             TrapToMM;
   logic             mretM;
   logic             sretM;
   logic [1:0]       PrivilegeModeW;
   logic             WriteMSTATUSM;
   logic             WriteSSTATUSM;
   logic             WriteMTRAPSTKM;
   logic [XLEN-1:0]  CSRWriteValM;
   logic             STATUS_MIE;
   logic             STATUS_SIE;
   logic             STATUS_MPIE;
   logic             STATUS_SPIE;
   logic [1:0]       STATUS_MPP;
   logic             STATUS_SPP;
   logic [XLEN-1:0]  MTRAPSTK_REGW;

   modport master (
      output StallW, TrapM, TrapToMM, mretM, sretM, PrivilegeModeW,
             WriteMSTATUSM, WriteSSTATUSM, WriteMTRAPSTKM, CSRWriteValM,
      input  STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE,
             STATUS_MPP, STATUS_SPP, MTRAPSTK_REGW
   );

   modport slave (
      input  StallW, TrapM, TrapToMM, mretM, sretM, PrivilegeModeW,
             WriteMSTATUSM, WriteSSTATUSM, WriteMTRAPSTKM, CSRWriteValM,
      output STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE,
             STATUS_MPP, STATUS_SPP, MTRAPSTK_REGW
   );
endinterface

// File: rtl/csr_trap_stack_save.sv
// trap_save_stack: DEPTH-level shift stack of {PIE,PP} save entries for one trap target.
// Latency: one cycle, state visible the cycle after push/pop/write0.
// Backpressure: none; the caller gates push/pop/write0/ovf_clr (mutually exclusive) with its stall.
// Ports: clk, reset_n, push/push_entry, pop, write0/write_entry, ovf_clr -> top, count, ovf.
// Optional: TRAP_STACK_STATUS_EN adds the level counter and overflow sticky, else count/ovf are 0.
module trap_save_stack
   import csr_trap_stack_pkg::*;
#(
   parameter int             DEPTH         = 4,
   parameter trapstk_entry_t DEFAULT_ENTRY = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      push,
   input  trapstk_entry_t            push_entry,
   input  logic                      pop,
   input  logic                      write0,
   input  trapstk_entry_t            write_entry,
   input  logic                      ovf_clr,
   output trapstk_entry_t            top,
   output logic [MTRAPSTK_CNT_W-1:0] count,
   output logic                      ovf
);

   localparam int CW = trapstk_cnt_w(DEPTH);

   trapstk_entry_t entry [DEPTH];

   // Push drops the deepest entry when full; pop refills the bottom with the
   // architectural default so DEPTH=1 reproduces the legacy xRET behaviour.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else if (push) begin
         entry[0] <= push_entry;
         for (int i = 1; i < DEPTH; i++) entry[i] <= entry[i-1];
      end else if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) entry[i] <= entry[i+1];
         entry[DEPTH-1] <= DEFAULT_ENTRY;
      end else if (write0) begin
         entry[0] <= write_entry;
      end
   end

   assign top = entry[0];

`ifdef TRAP_STACK_STATUS_EN
   logic [CW-1:0] cnt_q;
   logic          ovf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (push) begin
         // A single-level stack has no extra levels to count or overflow.
         if (DEPTH > 1) begin
            if (cnt_q == CW'(DEPTH - 1)) ovf_q <= 1'b1;
            else                         cnt_q <= cnt_q + 1'b1;
         end
      end else begin
         if (pop && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
         if (ovf_clr)            ovf_q <= 1'b0;
      end
   end

   assign count = MTRAPSTK_CNT_W'(cnt_q);
   assign ovf   = ovf_q;
`else
   logic unused_clr;
   assign unused_clr = ovf_clr;
   assign count      = '0;
   assign ovf        = 1'b0;
`endif

endmodule

// File: rtl/csr_trap_stack.sv
// csr_trap_stack: nested-trap status save stack owning MIE/SIE and DEPTH levels of xPIE/xPP for M and S.
// Latency: one cycle, outputs are registered and show an event the cycle after its edge.
// Backpressure: StallW=1 freezes every register; there is no other flow control.
// Ports: clk, reset_n (async, active-low), bus (csr_trap_stack_if.slave: events, write data, status outputs).
// Optional: define TRAP_STACK_STATUS_EN for level counts, overflow stickies and the MTRAPSTK view (W1C bits 8/9).
module csr_trap_stack
   import csr_trap_stack_pkg::*;
#(
   parameter cvw_t P     = CVW_DEFAULT,
   parameter int   DEPTH = 4
) (
   input logic              clk,
   input logic              reset_n,
   csr_trap_stack_if.slave  bus
);

   localparam int XLEN = P.XLEN;

   // Bottom-of-stack refill on xRET, matching legacy mret/sret side effects.
   localparam trapstk_entry_t M_DEF = '{pie: 1'b1, pp: (P.U_SUPPORTED ? U_MODE : M_MODE)};
   localparam trapstk_entry_t S_DEF = '{pie: P.S_SUPPORTED, pp: 2'b00};

   logic mie, sie;
   logic ev_trap, ev_mret, ev_sret, ev_wm, ev_ws, ev_wstk;
   logic push_m, push_s;

   trapstk_entry_t m_top, s_top;
   trapstk_entry_t m_push, s_push, m_wr, s_wr;
   logic [MTRAPSTK_CNT_W-1:0] m_cnt, s_cnt;
   logic m_ovf, s_ovf;

   // One event per cycle, highest priority first; a stall suppresses all.
   assign ev_trap = ~bus.StallW & bus.TrapM;
   assign ev_mret = ~bus.StallW & ~bus.TrapM & bus.mretM;
   assign ev_sret = ~bus.StallW & ~bus.TrapM & ~bus.mretM & bus.sretM;
   assign ev_wm   = ~bus.StallW & ~bus.TrapM & ~bus.mretM & ~bus.sretM & bus.WriteMSTATUSM;
   assign ev_ws   = ~bus.StallW & ~bus.TrapM & ~bus.mretM & ~bus.sretM & ~bus.WriteMSTATUSM
                    & bus.WriteSSTATUSM;
   assign ev_wstk = ~bus.StallW & ~bus.TrapM & ~bus.mretM & ~bus.sretM & ~bus.WriteMSTATUSM
                    & ~bus.WriteSSTATUSM & bus.WriteMTRAPSTKM;

   assign push_m = ev_trap & bus.TrapToMM;
   assign push_s = ev_trap & ~bus.TrapToMM;

   // S only keeps one bit of previous privilege (U or S).
   assign m_push = '{pie: mie, pp: bus.PrivilegeModeW};
   assign s_push = '{pie: sie, pp: {1'b0, bus.PrivilegeModeW[0]}};

   assign m_wr = '{pie: bus.CSRWriteValM[7],
                   pp:  legal_mpp(bus.CSRWriteValM[12:11], P.S_SUPPORTED, P.U_SUPPORTED)};
   assign s_wr = '{pie: bus.CSRWriteValM[5] & P.S_SUPPORTED,
                   pp:  {1'b0, bus.CSRWriteValM[8] & P.S_SUPPORTED}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mie <= 1'b0;
         sie <= 1'b0;
      end else begin
         if (push_m)      mie <= 1'b0;
         else if (ev_mret) mie <= m_top.pie;
         else if (ev_wm)   mie <= bus.CSRWriteValM[3];

         if (push_s)              sie <= 1'b0;
         else if (ev_sret)         sie <= s_top.pie;
         else if (ev_wm | ev_ws)   sie <= bus.CSRWriteValM[1] & P.S_SUPPORTED;
      end
   end

   trap_save_stack #(.DEPTH(DEPTH), .DEFAULT_ENTRY(M_DEF)) u_m_stack (
      .clk         (clk),
      .reset_n     (reset_n),
      .push        (push_m),
      .push_entry  (m_push),
      .pop         (ev_mret),
      .write0      (ev_wm),
      .write_entry (m_wr),
      .ovf_clr     (ev_wstk & bus.CSRWriteValM[MTRAPSTK_MOVF_BIT]),
      .top         (m_top),
      .count       (m_cnt),
      .ovf         (m_ovf)
   );

   trap_save_stack #(.DEPTH(DEPTH), .DEFAULT_ENTRY(S_DEF)) u_s_stack (
      .clk         (clk),
      .reset_n     (reset_n),
      .push        (push_s),
      .push_entry  (s_push),
      .pop         (ev_sret),
      .write0      (ev_wm | ev_ws),
      .write_entry (s_wr),
      .ovf_clr     (ev_wstk & bus.CSRWriteValM[MTRAPSTK_SOVF_BIT]),
      .top         (s_top),
      .count       (s_cnt),
      .ovf         (s_ovf)
   );

   assign bus.STATUS_MIE  = mie;
   assign bus.STATUS_SIE  = sie;
   assign bus.STATUS_MPIE = m_top.pie;
   assign bus.STATUS_SPIE = s_top.pie;
   assign bus.STATUS_MPP  = m_top.pp;
   assign bus.STATUS_SPP  = s_top.pp[0];

`ifdef TRAP_STACK_STATUS_EN
   logic [XLEN-1:0] stk_view;

   always_comb begin
      stk_view = '0;
      stk_view[MTRAPSTK_MCNT_LSB +: MTRAPSTK_CNT_W] = m_cnt;
      stk_view[MTRAPSTK_SCNT_LSB +: MTRAPSTK_CNT_W] = s_cnt;
      stk_view[MTRAPSTK_MOVF_BIT]                  = m_ovf;
      stk_view[MTRAPSTK_SOVF_BIT]                  = s_ovf;
   end

   assign bus.MTRAPSTK_REGW = stk_view;
`else
   assign bus.MTRAPSTK_REGW = '0;
`endif

   // Write-data bits outside the status fields and the S PP high bit are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{bus.CSRWriteValM, s_top.pp[1], m_cnt, s_cnt, m_ovf, s_ovf};

endmodule

// File: tb/tb_csr_trap_stack.sv
// tb_csr_trap_stack: directed checks of the trap stack at DEPTH=4 plus a legacy-model run at DEPTH=1.
// Latency: expects every event visible one cycle after its edge.
// Backpressure: exercises StallW freeze alongside the event priority order.
module tb_csr_trap_stack;
   import csr_trap_stack_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   csr_trap_stack_if #(.XLEN(64)) bus  ();
   csr_trap_stack_if #(.XLEN(64)) bus1 ();

   csr_trap_stack #(.P(CVW_DEFAULT), .DEPTH(4)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
   csr_trap_stack #(.P(CVW_DEFAULT), .DEPTH(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

   // Status packed as {MIE,SIE,MPIE,SPIE,MPP[1:0],SPP}.
   function automatic logic [6:0] st();
      return {bus.STATUS_MIE, bus.STATUS_SIE, bus.STATUS_MPIE, bus.STATUS_SPIE,
              bus.STATUS_MPP, bus.STATUS_SPP};
   endfunction

   function automatic logic [6:0] st1();
      return {bus1.STATUS_MIE, bus1.STATUS_SIE, bus1.STATUS_MPIE, bus1.STATUS_SPIE,
              bus1.STATUS_MPP, bus1.STATUS_SPP};
   endfunction

   // Expected MTRAPSTK view for a given count/sticky state.
   function automatic logic [63:0] exp_regw(input logic [3:0] mc, input logic mo,
                                            input logic [3:0] sc, input logic so);
`ifdef TRAP_STACK_STATUS_EN
      return {54'b0, so, mo, sc, mc};
`else
      return 64'h0 & {54'b0, so, mo, sc, mc};
`endif
   endfunction

   task automatic idle();
      bus.StallW = 0; bus.TrapM = 0; bus.TrapToMM = 0; bus.mretM = 0; bus.sretM = 0;
      bus.PrivilegeModeW = 2'b00; bus.WriteMSTATUSM = 0; bus.WriteSSTATUSM = 0;
      bus.WriteMTRAPSTKM = 0; bus.CSRWriteValM = '0;
      bus1.StallW = 0; bus1.TrapM = 0; bus1.TrapToMM = 0; bus1.mretM = 0; bus1.sretM = 0;
      bus1.PrivilegeModeW = 2'b00; bus1.WriteMSTATUSM = 0; bus1.WriteSSTATUSM = 0;
      bus1.WriteMTRAPSTKM = 0; bus1.CSRWriteValM = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic trap_m(input logic [1:0] priv);
      bus.TrapM = 1; bus.TrapToMM = 1; bus.PrivilegeModeW = priv;
      tick();
   endtask

   task automatic mret();
      bus.mretM = 1;
      tick();
   endtask

   task automatic wr_mstatus(input logic [63:0] v);
      bus.WriteMSTATUSM = 1; bus.CSRWriteValM = v;
      tick();
   endtask

   task automatic wr_sstatus(input logic [63:0] v);
      bus.WriteSSTATUSM = 1; bus.CSRWriteValM = v;
      tick();
   endtask

   task automatic wr_trapstk(input logic [63:0] v);
      bus.WriteMTRAPSTKM = 1; bus.CSRWriteValM = v;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      vectors++;
      if ({st(), bus.MTRAPSTK_REGW} !== 71'h0) begin
         miscompares++;
         $display("FAIL reset_init: got st=%b regw=%h want all zero", st(), bus.MTRAPSTK_REGW);
      end
      #10;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_nested();
      logic [6:0] exp_st [7];
      logic [3:0] exp_cnt [7];
      exp_st[0] = 7'b1_0_1_0_00_0; exp_cnt[0] = 0;
      exp_st[1] = 7'b0_0_1_0_00_0; exp_cnt[1] = 1;
      exp_st[2] = 7'b0_0_0_0_11_0; exp_cnt[2] = 2;
      exp_st[3] = 7'b0_0_0_0_11_0; exp_cnt[3] = 3;
      exp_st[4] = 7'b0_0_0_0_11_0; exp_cnt[4] = 2;
      exp_st[5] = 7'b0_0_1_0_00_0; exp_cnt[5] = 1;
      exp_st[6] = 7'b1_0_1_0_00_0; exp_cnt[6] = 0;
      for (int k = 0; k < 7; k++) begin
         if (k == 0)      wr_mstatus(64'h88);
         else if (k == 1) trap_m(U_MODE);
         else if (k < 4)  trap_m(M_MODE);
         else             mret();
         vectors++;
         if (st() !== exp_st[k]) begin
            miscompares++;
            $display("FAIL nested_st[%0d]: got %b want %b", k, st(), exp_st[k]);
         end
         vectors++;
         if (bus.MTRAPSTK_REGW !== exp_regw(exp_cnt[k], 0, 0, 0)) begin
            miscompares++;
            $display("FAIL nested_cnt[%0d]: got %h want %h", k, bus.MTRAPSTK_REGW,
                     exp_regw(exp_cnt[k], 0, 0, 0));
         end
      end
   endtask

   task automatic test_async_reset();
      trap_m(M_MODE);
      vectors++;
      if (st() !== 7'b0_0_1_0_11_0) begin
         miscompares++;
         $display("FAIL pre_reset_st: got %b want %b", st(), 7'b0_0_1_0_11_0);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({st(), bus.MTRAPSTK_REGW} !== 71'h0) begin
         miscompares++;
         $display("FAIL async_reset: got st=%b regw=%h want all zero", st(), bus.MTRAPSTK_REGW);
      end
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_overflow();
      pulse_reset();
      for (int k = 1; k <= 5; k++) begin
         trap_m(M_MODE);
         vectors++;
         if (bus.MTRAPSTK_REGW !== exp_regw((k > 3) ? 4'd3 : 4'(k), k > 3, 0, 0)) begin
            miscompares++;
            $display("FAIL ovf_trap[%0d]: got %h want %h", k, bus.MTRAPSTK_REGW,
                     exp_regw((k > 3) ? 4'd3 : 4'(k), k > 3, 0, 0));
         end
      end
      vectors++;
      if (st() !== 7'b0_0_0_0_11_0) begin
         miscompares++;
         $display("FAIL ovf_st: got %b want %b", st(), 7'b0_0_0_0_11_0);
      end
      wr_trapstk(64'h200);
      vectors++;
      if (bus.MTRAPSTK_REGW !== exp_regw(3, 1, 0, 0)) begin
         miscompares++;
         $display("FAIL w1c_s_only: got %h want %h", bus.MTRAPSTK_REGW, exp_regw(3, 1, 0, 0));
      end
      wr_trapstk(64'h1FF);
      vectors++;
      if (bus.MTRAPSTK_REGW !== exp_regw(3, 0, 0, 0)) begin
         miscompares++;
         $display("FAIL w1c_m: got %h want %h", bus.MTRAPSTK_REGW, exp_regw(3, 0, 0, 0));
      end
      bus.WriteMTRAPSTKM = 1; bus.CSRWriteValM = 64'h100;
      trap_m(M_MODE);
      vectors++;
      if (bus.MTRAPSTK_REGW !== exp_regw(3, 1, 0, 0)) begin
         miscompares++;
         $display("FAIL trap_vs_w1c: got %h want %h", bus.MTRAPSTK_REGW, exp_regw(3, 1, 0, 0));
      end
   endtask

   task automatic test_priority();
      pulse_reset();
      wr_mstatus(64'h8);
      bus.mretM = 1; bus.WriteMSTATUSM = 1; bus.CSRWriteValM = 64'h1888;
      trap_m(U_MODE);
      vectors++;
      if (st() !== 7'b0_0_1_0_00_0) begin
         miscompares++;
         $display("FAIL prio_push: got %b want %b", st(), 7'b0_0_1_0_00_0);
      end
      bus.StallW = 1; bus.WriteMSTATUSM = 1; bus.CSRWriteValM = 64'h8;
      trap_m(M_MODE);
      vectors++;
      if ({st(), bus.MTRAPSTK_REGW} !== {7'b0_0_1_0_00_0, exp_regw(1, 0, 0, 0)}) begin
         miscompares++;
         $display("FAIL stall_freeze: got st=%b regw=%h want st=%b regw=%h", st(),
                  bus.MTRAPSTK_REGW, 7'b0_0_1_0_00_0, exp_regw(1, 0, 0, 0));
      end
      bus.mretM = 1; bus.sretM = 1; bus.WriteSSTATUSM = 1; bus.CSRWriteValM = 64'h122;
      tick();
      vectors++;
      if (st() !== 7'b1_0_0_0_00_0) begin
         miscompares++;
         $display("FAIL prio_mret: got %b want %b", st(), 7'b1_0_0_0_00_0);
      end
   endtask

   task automatic test_legalise();
      logic [63:0] wv  [4];
      logic [1:0]  mpp [4];
      pulse_reset();
      wv[0] = 64'h1000; mpp[0] = 2'b11;
      wv[1] = 64'h0800; mpp[1] = 2'b01;
      wv[2] = 64'h1800; mpp[2] = 2'b11;
      wv[3] = 64'h0000; mpp[3] = 2'b00;
      for (int k = 0; k < 4; k++) begin
         wr_mstatus(wv[k]);
         vectors++;
         if (bus.STATUS_MPP !== mpp[k]) begin
            miscompares++;
            $display("FAIL mpp_legal[%0d]: got %b want %b", k, bus.STATUS_MPP, mpp[k]);
         end
      end
      wr_mstatus(64'h8);
      wr_sstatus(64'h122);
      vectors++;
      if (st() !== 7'b1_1_0_1_00_1) begin
         miscompares++;
         $display("FAIL sstatus_wr: got %b want %b", st(), 7'b1_1_0_1_00_1);
      end
      wr_sstatus(64'h8);
      vectors++;
      if (st() !== 7'b1_0_0_0_00_0) begin
         miscompares++;
         $display("FAIL sstatus_mie_kept: got %b want %b", st(), 7'b1_0_0_0_00_0);
      end
      wr_sstatus(64'h122);
      bus.TrapM = 1; bus.TrapToMM = 0; bus.PrivilegeModeW = U_MODE;
      tick();
      vectors++;
      if ({st(), bus.MTRAPSTK_REGW} !== {7'b1_0_0_1_00_0, exp_regw(0, 0, 1, 0)}) begin
         miscompares++;
         $display("FAIL s_trap: got st=%b regw=%h want st=%b regw=%h", st(),
                  bus.MTRAPSTK_REGW, 7'b1_0_0_1_00_0, exp_regw(0, 0, 1, 0));
      end
      bus.sretM = 1;
      tick();
      vectors++;
      if ({st(), bus.MTRAPSTK_REGW} !== {7'b1_1_0_1_00_1, exp_regw(0, 0, 0, 0)}) begin
         miscompares++;
         $display("FAIL sret: got st=%b regw=%h want st=%b regw=%h", st(),
                  bus.MTRAPSTK_REGW, 7'b1_1_0_1_00_1, exp_regw(0, 0, 0, 0));
      end
   endtask

   // DEPTH=1 against the legacy single-level mstatus behaviour.
   task automatic test_depth1();
      logic       mie = 0, sie = 0, mpie = 0, spie = 0, spp = 0;
      logic [1:0] mpp = 0;
      logic [1:0] priv;
      logic [63:0] v;
      int op;
      pulse_reset();
      for (int k = 0; k < 60; k++) begin
         op = $urandom_range(0, 6);
         case ($urandom_range(0, 2))
            0:       priv = U_MODE;
            1:       priv = S_MODE;
            default: priv = M_MODE;
         endcase
         v = 64'($urandom_range(0, 32'h1FFF));
         bus1.PrivilegeModeW = priv;
         bus1.CSRWriteValM = v;
         case (op)
            0: begin bus1.TrapM = 1; bus1.TrapToMM = 1; mpie = mie; mie = 0; mpp = priv; end
            1: begin bus1.TrapM = 1; spie = sie; sie = 0; spp = priv[0]; end
            2: begin bus1.mretM = 1; mie = mpie; mpie = 1; mpp = U_MODE; end
            3: begin bus1.sretM = 1; sie = spie; spie = 1; spp = 0; end
            4: begin
               bus1.WriteMSTATUSM = 1;
               mie = v[3]; sie = v[1]; mpie = v[7]; spie = v[5]; spp = v[8];
               mpp = (v[12:11] == 2'b00) ? U_MODE : (v[12:11] == 2'b01) ? S_MODE : M_MODE;
            end
            5: begin bus1.WriteSSTATUSM = 1; sie = v[1]; spie = v[5]; spp = v[8]; end
            default: begin bus1.StallW = 1; bus1.TrapM = 1; bus1.TrapToMM = 1; end
         endcase
         tick();
         vectors++;
         if ({st1(), bus1.MTRAPSTK_REGW} !== {mie, sie, mpie, spie, mpp, spp, 64'h0}) begin
            miscompares++;
            $display("FAIL depth1[%0d] op%0d: got st=%b regw=%h want st=%b regw=0", k, op,
                     st1(), bus1.MTRAPSTK_REGW, {mie, sie, mpie, spie, mpp, spp});
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_nested();
      test_async_reset();
      test_overflow();
      test_priority();
      test_legalise();
      test_depth1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
